// File: rtl/ninja_round_ctrl_pkg.sv
// Shared types and defaults for the ninja reaction game controller.
// ROUND_SPEEDUP_EN (see ninja_round_ctrl) shrinks the window per level, floored at MIN_WINDOW.
package ninja_round_ctrl_pkg;

    localparam int WINDOW_TICKS_DEF = 40;
    localparam int SHOW_TICKS_DEF   = 10;
    localparam int MIN_WINDOW       = 16;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam logic [1:0] ACT_0 = 2'd0;
    localparam logic [1:0] ACT_1 = 2'd1;
    localparam logic [1:0] ACT_2 = 2'd2;
    localparam logic [1:0] ACT_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

endpackage

// File: rtl/ninja_round_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every clock.
module lfsr8
    import ninja_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/ninja_round_ctrl.sv
// Round/level/score controller for the ninja reaction game.
// Define ROUND_SPEEDUP_EN to shorten the response window by 8 ticks per level.
module ninja_round_ctrl
    import ninja_round_ctrl_pkg::*;
#(
    parameter int WINDOW_TICKS     = WINDOW_TICKS_DEF,
    parameter int SHOW_TICKS       = SHOW_TICKS_DEF,
    parameter int ROUNDS_PER_LEVEL = 8,
    parameter int MAX_WRONG        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] action,
    output logic [7:0] count,
    output logic [2:0] level,
    output logic [7:0] wrong_time,
    output logic [7:0] score,
    output logic       hit,
    output logic       miss,
    output logic       window_open,
    output logic       game_over,
    output state_e     state_dbg
);

    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[7:2];

    state_e     state_q, state_d;
    logic [3:0] action_q, action_d;
    logic [7:0] count_q, count_d;
    logic [7:0] show_cnt_q, show_cnt_d;
    logic [7:0] round_q, round_d;
    logic [2:0] level_q, level_d;
    logic [7:0] wrong_q, wrong_d;
    logic [7:0] score_q, score_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
    logic       open_q, open_d;
    logic       over_q, over_d;

    logic [7:0] window;
    logic [1:0] btn_code;
    logic       btn_any;

`ifdef ROUND_SPEEDUP_EN
    int win_calc;
    always_comb begin
        win_calc = WINDOW_TICKS - 8 * (int'(level_q) - 1);
        if (win_calc < MIN_WINDOW) begin
            win_calc = MIN_WINDOW;
        end
        window = 8'(win_calc);
    end
`else
    assign window = 8'(WINDOW_TICKS);
`endif

    // Lowest button index has priority when several pulse together.
    always_comb begin
        btn_any  = |btn;
        btn_code = ACT_0;
        if (btn[0]) begin
            btn_code = ACT_3;
        end else if (btn[1]) begin
            btn_code = ACT_2;
        end else if (btn[2]) begin
            btn_code = ACT_1;
        end
    end

    always_comb begin
        state_d    = state_q;
        action_d   = action_q;
        count_d    = count_q;
        show_cnt_d = show_cnt_q;
        round_d    = round_q;
        level_d    = level_q;
        wrong_d    = wrong_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d    = ST_SHOW;
                    level_d    = 3'd1;
                    round_d    = 8'd0;
                    score_d    = 8'd0;
                    wrong_d    = 8'd0;
                    count_d    = 8'd0;
                    show_cnt_d = 8'd0;
                    action_d   = {2'b00, lfsr_q[1:0]};
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (show_cnt_q == 8'(SHOW_TICKS - 1)) begin
                        state_d    = ST_WAIT;
                        show_cnt_d = 8'd0;
                        count_d    = 8'd0;
                    end else begin
                        show_cnt_d = show_cnt_q + 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                // A press on the timeout tick is judged; the tick is then moot.
                if (btn_any) begin
                    state_d = ST_RESULT;
                    if (btn_code == action_q[1:0]) begin
                        hit_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else begin
                        miss_d = 1'b1;
                        if (wrong_q != 8'hFF) wrong_d = wrong_q + 8'd1;
                    end
                end else if (tick) begin
                    if (count_q == window - 8'd1) begin
                        state_d = ST_RESULT;
                        miss_d  = 1'b1;
                        if (wrong_q != 8'hFF) wrong_d = wrong_q + 8'd1;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            ST_RESULT: begin
                if (tick) begin
                    if (wrong_q >= 8'(MAX_WRONG)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d  = ST_SHOW;
                        count_d  = 8'd0;
                        action_d = {2'b00, lfsr_q[1:0]};
                        if (round_q == 8'(ROUNDS_PER_LEVEL - 1)) begin
                            round_d = 8'd0;
                            if (level_q != 3'd7) level_d = level_q + 3'd1;
                        end else begin
                            round_d = round_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        open_d = (state_d == ST_WAIT);
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            action_q   <= 4'd0;
            count_q    <= 8'd0;
            show_cnt_q <= 8'd0;
            round_q    <= 8'd0;
            level_q    <= 3'd0;
            wrong_q    <= 8'd0;
            score_q    <= 8'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            open_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            action_q   <= action_d;
            count_q    <= count_d;
            show_cnt_q <= show_cnt_d;
            round_q    <= round_d;
            level_q    <= level_d;
            wrong_q    <= wrong_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            open_q     <= open_d;
            over_q     <= over_d;
        end
    end

    assign action      = action_q;
    assign count       = count_q;
    assign level       = level_q;
    assign wrong_time  = wrong_q;
    assign score       = score_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign window_open = open_q;
    assign game_over   = over_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ninja_round_ctrl.sv
// Bench for ninja_round_ctrl: table of rounds plus hand sequences for game over and reset.
// Result pulses are checked against an expected queue filled when the judging input is driven.
module tb_ninja_round_ctrl;
    import ninja_round_ctrl_pkg::*;

    localparam int WIN  = 40;
    localparam int SHOW = 10;

    localparam int K_OK    = 0;
    localparam int K_WRONG = 1;
    localparam int K_MULTI = 2;
    localparam int K_TOUT  = 3;
    localparam int K_EDGE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [3:0] action;
    logic [7:0] count;
    logic [2:0] level;
    logic [7:0] wrong_time;
    logic [7:0] score;
    logic       hit;
    logic       miss;
    logic       window_open;
    logic       game_over;
    state_e     state_dbg;

    always #5 clk = ~clk;

    ninja_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .btn         (btn),
        .action      (action),
        .count       (count),
        .level       (level),
        .wrong_time  (wrong_time),
        .score       (score),
        .hit         (hit),
        .miss        (miss),
        .window_open (window_open),
        .game_over   (game_over),
        .state_dbg   (state_dbg)
    );

    // Reference sequence x^8+x^6+x^5+x^4+1 from seed A5.
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_e;
    int exp_act;
    int cur_level;

    typedef struct {
        int kind;
        int delay;
        int exp_score;
        int exp_wrong;
        int exp_level;
        bit exp_over;
    } round_t;

    round_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic [3:0] b);
        tick  = t;
        start = s;
        btn   = b;
        @(negedge clk);
        tick  = 1'b0;
        start = 1'b0;
        btn   = 4'd0;
    endtask

    function automatic int win_for(input int lvl);
`ifdef ROUND_SPEEDUP_EN
        int w;
        w = WIN - 8 * (lvl - 1);
        return (w < 16) ? 16 : w;
`else
        return WIN;
`endif
    endfunction

    function automatic logic [3:0] btn_for(input int code);
        logic [3:0] one;
        one = 4'b0001;
        return one << (3 - code);
    endfunction

    function automatic logic [17:0] pack(input bit h, input bit m, input int s, input int w);
        return {h, m, 8'(s), 8'(w)};
    endfunction

    always @(negedge clk) begin
        if (!rst && (hit || miss)) begin
            chk("hit_miss_exclusive", int'(hit & miss), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b with none expected at %0t", hit, miss, $time);
            end else begin
                exp_e = exp_q.pop_front();
                chk("result_pulse", int'({hit, miss, score, wrong_time}), int'(exp_e));
            end
        end
    end

    task automatic play_round(input round_t r);
        int w;
        int code;
        int next_act;
        logic [3:0] b;
        logic [3:0] all_ones;
        w = win_for(cur_level);
        next_act = exp_act;
        all_ones = 4'b1111;
        chk("show_action", int'(action), exp_act);
        chk("show_closed", int'(window_open), 0);
        cyc(1'b0, 1'b0, btn_for(exp_act));
        cyc(1'b0, 1'b1, 4'd0);
        chk("show_start_ignored", int'(action), exp_act);
        repeat (SHOW) cyc(1'b1, 1'b0, 4'd0);
        chk("wait_open", int'(window_open), 1);
        chk("wait_count0", int'(count), 0);
        case (r.kind)
            K_TOUT: begin
                repeat (w - 1) cyc(1'b1, 1'b0, 4'd0);
                chk("tout_count", int'(count), w - 1);
                exp_q.push_back(pack(1'b0, 1'b1, r.exp_score, r.exp_wrong));
                cyc(1'b1, 1'b0, 4'd0);
                chk("tout_count_hold", int'(count), w - 1);
            end
            K_EDGE: begin
                repeat (w - 1) cyc(1'b1, 1'b0, 4'd0);
                exp_q.push_back(pack(1'b1, 1'b0, r.exp_score, r.exp_wrong));
                cyc(1'b1, 1'b0, btn_for(exp_act));
            end
            default: begin
                repeat (r.delay) cyc(1'b1, 1'b0, 4'd0);
                chk("wait_count", int'(count), r.delay);
                code = (r.kind == K_WRONG) ? (exp_act + 1) % 4 : exp_act;
                b = (r.kind == K_MULTI) ? (all_ones << (3 - code)) : btn_for(code);
                exp_q.push_back(pack(r.kind != K_WRONG, r.kind == K_WRONG, r.exp_score, r.exp_wrong));
                cyc(1'b0, 1'b0, b);
            end
        endcase
        chk("judged_closed", int'(window_open), 0);
        cyc(1'b0, 1'b0, 4'd0);
        chk("pulse_seen", exp_q.size(), 0);
        if (!r.exp_over) next_act = int'(lfsr_m[1:0]);
        cyc(1'b1, 1'b0, 4'd0);
        chk("round_level", int'(level), r.exp_level);
        chk("round_score", int'(score), r.exp_score);
        chk("round_wrong", int'(wrong_time), r.exp_wrong);
        chk("round_over", int'(game_over), int'(r.exp_over));
        exp_act = next_act;
        cur_level = r.exp_level;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{K_OK,    3, 1, 0, 1, 1'b0};
        tbl[1]  = '{K_WRONG, 0, 1, 1, 1, 1'b0};
        tbl[2]  = '{K_TOUT,  0, 1, 2, 1, 1'b0};
        tbl[3]  = '{K_MULTI, 5, 2, 2, 1, 1'b0};
        tbl[4]  = '{K_EDGE,  0, 3, 2, 1, 1'b0};
        tbl[5]  = '{K_OK,    1, 4, 2, 1, 1'b0};
        tbl[6]  = '{K_OK,    0, 5, 2, 1, 1'b0};
        tbl[7]  = '{K_OK,    2, 6, 2, 2, 1'b0};
        tbl[8]  = '{K_TOUT,  0, 6, 3, 2, 1'b0};
        tbl[9]  = '{K_WRONG, 4, 6, 4, 2, 1'b0};
        tbl[10] = '{K_WRONG, 0, 6, 5, 2, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_state", int'(state_dbg), int'(ST_IDLE));
        chk("rst_level", int'(level), 0);
        chk("rst_action", int'(action), 0);
        chk("rst_flags", int'({hit, miss, window_open, game_over}), 0);
        rst = 1'b0;

        cyc(1'b1, 1'b0, 4'b1111);
        chk("idle_ignores_inputs", int'(state_dbg), int'(ST_IDLE));
        exp_act = int'(lfsr_m[1:0]);
        cur_level = 1;
        cyc(1'b0, 1'b1, 4'd0);
        chk("start_level", int'(level), 1);
        chk("start_state", int'(state_dbg), int'(ST_SHOW));

        for (int i = 0; i < 11; i++) begin
            play_round(tbl[i]);
        end

        chk("over_state", int'(state_dbg), int'(ST_OVER));
        repeat (3) cyc(1'b1, 1'b0, 4'b0001);
        chk("over_hold_score", int'(score), 6);
        chk("over_hold_wrong", int'(wrong_time), 5);
        chk("over_hold_flag", int'(game_over), 1);
        exp_act = int'(lfsr_m[1:0]);
        cyc(1'b0, 1'b1, 4'd0);
        chk("restart_level", int'(level), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_wrong", int'(wrong_time), 0);
        chk("restart_over", int'(game_over), 0);
        chk("restart_action", int'(action), exp_act);

        repeat (SHOW + 3) cyc(1'b1, 1'b0, 4'd0);
        chk("pre_rst_open", int'(window_open), 1);
        chk("pre_rst_count", int'(count), 3);
        rst = 1'b1;
        cyc(1'b1, 1'b0, btn_for(exp_act));
        chk("mid_rst_pulses", int'({hit, miss}), 0);
        chk("mid_rst_outputs", int'({action, count, level, wrong_time, score}), 0);
        chk("mid_rst_flags", int'({window_open, game_over}), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, btn_for(exp_act));
        chk("post_rst_state", int'(state_dbg), int'(ST_IDLE));
        chk("post_rst_pulses", int'({hit, miss}), 0);
        exp_act = int'(lfsr_m[1:0]);
        cyc(1'b0, 1'b1, 4'd0);
        chk("post_rst_action", int'(action), exp_act);

        cyc(1'b0, 1'b0, 4'd0);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
